// File: rtl/nsp_pkg.sv
// Shared constants, state encoding and the fp16 step helper for the layer sequencer.
package nsp_pkg;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_RUN   = RUN,
        S_DRAIN = DRAIN,
        S_FIN   = FIN
    } state_t;

    // Only the sign decides; NaN and Inf simply follow their sign bit.
    function automatic logic [15:0] fp16_step(input logic [15:0] value);
        return value[15] ? FP16_ZERO : FP16_ONE;
    endfunction

endpackage

// File: rtl/act_skid_buf.sv
// Two-entry FIFO of {address, stepped value} between the read return and the activation write port.
module act_skid_buf #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [15:0]       i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [1:0]        o_count,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [15:0]       o_head_data
);

    logic [ADDR_W-1:0] r_addr [2];
    logic [15:0]       r_data [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // A push into a full buffer is still honoured when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr[0] <= '0;
            r_addr[1] <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_addr[r_wptr] <= i_push_addr;
                r_data[r_wptr] <= i_push_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_full      = (r_count == 2'd2);
    assign o_empty     = (r_count == 2'd0);
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];

endmodule

// File: rtl/step_layer_sequencer.sv
// Walks one layer of fp16 pre-activations, applies the step function and streams results out.
// Optional FIRE_COUNT_EN adds o_fire_count, the number of 1.0 results written in the current layer.
module step_layer_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_neurons,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [15:0]       i_rd_data,
    output logic              o_wr_en,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data
`ifdef FIRE_COUNT_EN
    ,
    output logic [ADDR_W-1:0] o_fire_count
`endif
);

    import nsp_pkg::*;

    state_t            r_state;
    logic [ADDR_W-1:0] r_num;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_ret_addr;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;

    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_count;
    logic [ADDR_W-1:0] w_head_addr;
    logic [15:0]       w_head_data;
    logic [15:0]       w_step_data;
    logic              w_pop;
    logic [2:0]        w_credit;
    logic              w_rd_en;
    logic              w_last_rd;
    logic              w_last_wr;

    assign w_step_data = fp16_step(i_rd_data);
    assign w_pop       = !w_empty && i_wr_ready;

    // Discounting this cycle's pop is what lets a 2-entry buffer sustain one neuron per cycle.
    assign w_credit  = {2'b00, r_inflight} + {1'b0, w_count} - {2'b00, w_pop};
    assign w_rd_en   = (r_state == S_RUN) && (w_credit < 3'd2) && !(w_full && !w_pop);
    assign w_last_rd = w_rd_en && (r_rd_addr == r_num - ADDR_W'(1));
    assign w_last_wr = w_pop && (w_head_addr == r_num - ADDR_W'(1));

    act_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_addr (r_ret_addr),
        .i_push_data (w_step_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_rd_addr  <= '0;
            r_ret_addr <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= 1'b0;
            if (w_rd_en) begin
                r_ret_addr <= r_rd_addr;
                r_rd_addr  <= r_rd_addr + ADDR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num     <= i_num_neurons;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        if (i_num_neurons == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last_rd) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_last_wr) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIRE_COUNT_EN
    logic [ADDR_W-1:0] r_fire_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fire_count <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_fire_count <= '0;
        end else if (w_pop && (w_head_data == FP16_ONE)) begin
            r_fire_count <= r_fire_count + ADDR_W'(1);
        end
    end

    assign o_fire_count = r_fire_count;
`endif

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rd_en   = w_rd_en;
    assign o_rd_addr = r_rd_addr;
    assign o_wr_en   = !w_empty;
    assign o_wr_addr = w_head_addr;
    assign o_wr_data = w_head_data;

endmodule

// File: tb/tb_step_layer_sequencer.sv
// Directed bench for step_layer_sequencer with a 1-cycle-latency neuron RAM model and a write logger.
module tb_step_layer_sequencer;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] numNeurons;
    logic              busy;
    logic              done;
    logic              rdEn;
    logic [ADDR_W-1:0] rdAddr;
    logic [15:0]       rdData;
    logic              wrEn;
    logic              wrReady;
    logic [ADDR_W-1:0] wrAddr;
    logic [15:0]       wrData;
`ifdef FIRE_COUNT_EN
    logic [ADDR_W-1:0] fireCount;
`endif

    logic [15:0] mem     [256];
    logic [15:0] expData [256];

    logic [ADDR_W-1:0] wrAddrQ [$];
    logic [15:0]       wrDataQ [$];
    int                wrCycleQ [$];
    int cycleCnt = 0;
    int doneCount;
    int doneCycle;
    int rdCount;
    int acceptCycle;
    int assertCount = 0;
    int failCount = 0;

    step_layer_sequencer #(.ADDR_W(ADDR_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_num_neurons (numNeurons),
        .o_busy        (busy),
        .o_done        (done),
        .o_rd_en       (rdEn),
        .o_rd_addr     (rdAddr),
        .i_rd_data     (rdData),
        .o_wr_en       (wrEn),
        .i_wr_ready    (wrReady),
        .o_wr_addr     (wrAddr),
        .o_wr_data     (wrData)
`ifdef FIRE_COUNT_EN
        ,
        .o_fire_count  (fireCount)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // RAM returns data exactly one cycle after a read strobe; junk otherwise.
    always @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddr];
        else      rdData <= 16'hFFFF;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wrEn && wrReady) begin
                wrAddrQ.push_back(wrAddr);
                wrDataQ.push_back(wrData);
                wrCycleQ.push_back(cycleCnt);
            end
            if (done) begin
                doneCount = doneCount + 1;
                doneCycle = cycleCnt;
            end
            if (rdEn) rdCount = rdCount + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] n);
        start      = 1'b1;
        numNeurons = n;
        @(posedge clk);
        #1;
        start       = 1'b0;
        acceptCycle = cycleCnt;
    endtask

    task automatic clearLog();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycleQ.delete();
        doneCount = 0;
        doneCycle = 0;
        rdCount   = 0;
    endtask

    task automatic waitDone(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, " done seen"}, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, " busy low after done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic checkWrites(input int n, input string tag);
        checkOutput({tag, " write count"}, wrAddrQ.size(), n);
        for (int i = 0; i < n && i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("%s wr_addr[%0d]", tag, i), {24'd0, wrAddrQ[i]}, i);
            checkOutput($sformatf("%s wr_data[%0d]", tag, i), {16'd0, wrDataQ[i]}, {16'd0, expData[i]});
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        numNeurons = '0;
        wrReady    = 1'b1;
        clearLog();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy",    {31'd0, busy}, 32'd0);
        checkOutput("reset done",    {31'd0, done}, 32'd0);
        checkOutput("reset rd_en",   {31'd0, rdEn}, 32'd0);
        checkOutput("reset wr_en",   {31'd0, wrEn}, 32'd0);
        checkOutput("reset rd_addr", {24'd0, rdAddr}, 32'd0);
        checkOutput("reset wr_addr", {24'd0, wrAddr}, 32'd0);
        checkOutput("reset wr_data", {16'd0, wrData}, 32'd0);
`ifdef FIRE_COUNT_EN
        checkOutput("reset fire_count", {24'd0, fireCount}, 32'd0);
`endif

        // Layer of four, mixed signs, ready always high.
        @(posedge clk);
        #1;
        mem[0] = 16'h3C00; mem[1] = 16'hBC00; mem[2] = 16'h0000; mem[3] = 16'h8000;
        expData[0] = 16'h3C00; expData[1] = 16'h0000; expData[2] = 16'h3C00; expData[3] = 16'h0000;
        clearLog();
        applyStimulus(8'd4);
        waitDone(50, "t1");
        checkWrites(4, "t1");
        checkOutput("t1 first write latency", wrCycleQ[0] - acceptCycle, 32'd2);
        checkOutput("t1 back-to-back writes", wrCycleQ[3] - wrCycleQ[0], 32'd3);
        checkOutput("t1 done after last write", doneCycle - wrCycleQ[3], 32'd1);
        checkOutput("t1 done pulses", doneCount, 32'd1);
        checkOutput("t1 reads", rdCount, 32'd4);
`ifdef FIRE_COUNT_EN
        checkOutput("t1 fire_count", {24'd0, fireCount}, 32'd2);
`endif

        // Empty layer.
        clearLog();
        applyStimulus(8'd0);
        @(negedge clk);
        checkOutput("t2 busy in done cycle", {31'd0, busy}, 32'd1);
        checkOutput("t2 done pulse",         {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("t2 busy after",         {31'd0, busy}, 32'd0);
        checkOutput("t2 done cleared",       {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t2 reads",  rdCount, 32'd0);
        checkOutput("t2 writes", wrAddrQ.size(), 32'd0);
`ifdef FIRE_COUNT_EN
        checkOutput("t2 fire_count", {24'd0, fireCount}, 32'd0);
`endif

        // Backpressure during cycles 3..6 after start.
        mem[0] = 16'h0001; mem[1] = 16'h8001; mem[2] = 16'h8000; mem[3] = 16'h7C00;
        mem[4] = 16'hFC00; mem[5] = 16'h7E00; mem[6] = 16'hFE00; mem[7] = 16'h0000;
        expData[0] = 16'h3C00; expData[1] = 16'h0000; expData[2] = 16'h0000; expData[3] = 16'h3C00;
        expData[4] = 16'h0000; expData[5] = 16'h3C00; expData[6] = 16'h0000; expData[7] = 16'h3C00;
        clearLog();
        applyStimulus(8'd8);
        repeat (3) @(posedge clk);
        #1;
        wrReady = 1'b0;
        checkOutput("t3 reads before stall", rdCount, 32'd3);
        repeat (3) @(negedge clk);
        checkOutput("t3 stalled wr_en",   {31'd0, wrEn}, 32'd1);
        checkOutput("t3 stalled wr_addr", {24'd0, wrAddr}, 32'd1);
        checkOutput("t3 stalled wr_data", {16'd0, wrData}, 32'h0000);
        checkOutput("t3 stalled rd_en",   {31'd0, rdEn}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wrReady = 1'b1;
        checkOutput("t3 no reads during stall", rdCount, 32'd3);
        waitDone(100, "t3");
        checkWrites(8, "t3");
        checkOutput("t3 done pulses", doneCount, 32'd1);
        checkOutput("t3 reads", rdCount, 32'd8);

        // Restart attempts while busy and in the done cycle are ignored.
        for (int i = 0; i < 16; i++) begin
            mem[i]     = {i[0], 15'h1234};
            expData[i] = i[0] ? 16'h0000 : 16'h3C00;
        end
        clearLog();
        applyStimulus(8'd5);
        @(posedge clk);
        #1;
        applyStimulus(8'd2);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            checkOutput("t4 done seen", {31'd0, seen}, 32'd1);
        end
        start      = 1'b1;
        numNeurons = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("t4 start at done ignored", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkWrites(5, "t4");
        checkOutput("t4 done pulses", doneCount, 32'd1);
        checkOutput("t4 reads", rdCount, 32'd5);

        // Reset in the middle of a ten-neuron layer.
        clearLog();
        applyStimulus(8'd10);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (wrAddrQ.size() >= 3) break;
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5 busy after rst",    {31'd0, busy}, 32'd0);
        checkOutput("t5 done after rst",    {31'd0, done}, 32'd0);
        checkOutput("t5 rd_en after rst",   {31'd0, rdEn}, 32'd0);
        checkOutput("t5 wr_en after rst",   {31'd0, wrEn}, 32'd0);
        checkOutput("t5 rd_addr after rst", {24'd0, rdAddr}, 32'd0);
        checkOutput("t5 wr_addr after rst", {24'd0, wrAddr}, 32'd0);
        checkOutput("t5 wr_data after rst", {16'd0, wrData}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5 no done after rst", doneCount, 32'd0);
        checkOutput("t5 writes before rst", wrAddrQ.size(), 32'd3);
        clearLog();
        applyStimulus(8'd2);
        waitDone(50, "t5");
        checkWrites(2, "t5");
        checkOutput("t5 done pulses", doneCount, 32'd1);
`ifdef FIRE_COUNT_EN
        checkOutput("t5 fire_count", {24'd0, fireCount}, 32'd1);
`endif

        // Largest layer, alternating signs starting positive.
        for (int i = 0; i < 255; i++) begin
            mem[i] = i[0] ? 16'hC000 : 16'h4000;
        end
        clearLog();
        applyStimulus(8'd255);
        waitDone(1000, "t6");
        checkOutput("t6 write count", wrAddrQ.size(), 32'd255);
        begin
            int bad = 0;
            for (int i = 0; i < 255 && i < wrAddrQ.size(); i++) begin
                if (wrAddrQ[i] !== 8'(i)) bad++;
                if (wrDataQ[i] !== (i[0] ? 16'h0000 : 16'h3C00)) bad++;
            end
            checkOutput("t6 bad entries", bad, 32'd0);
        end
        if (wrCycleQ.size() == 255) begin
            checkOutput("t6 throughput span", wrCycleQ[254] - wrCycleQ[0], 32'd254);
        end
        checkOutput("t6 done pulses", doneCount, 32'd1);
`ifdef FIRE_COUNT_EN
        checkOutput("t6 fire_count", {24'd0, fireCount}, 32'd128);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
